// File: rtl/signed_vector_scale.sv
// signed_vector_scale: multiplies a packed sign-magnitude Q8.10 vector {x, y, z}
// by a sign-magnitude Q8.10 scalar, one component per cycle through a single
// shared 18x18 magnitude multiplier. Results saturate per component and never
// carry a negative zero.
module signed_vector_scale (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [56:0] in_vector,
    input  logic [18:0] in_scalar,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [56:0] out_vector,
    output logic [2:0]  out_ovf,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_X = 3'd1,
        MUL_Y = 3'd2,
        MUL_Z = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    // Operand registers, captured on the accept edge so upstream is free afterwards
    logic [56:0] op_vector;
    logic [18:0] op_scalar;

    // Shared datapath signals
    logic [18:0] cur_comp;
    logic [35:0] product;
    logic [25:0] quot;
    logic        sat;
    logic [17:0] res_mag;
    logic        res_sign;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = MUL_X;
                end
            end
            MUL_X: state_next = MUL_Y;
            MUL_Y: state_next = MUL_Z;
            MUL_Z: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the component for the current multiply state
    always_comb begin
        cur_comp = op_vector[18:0];
        case (state)
            MUL_X:   cur_comp = op_vector[56:38];
            MUL_Y:   cur_comp = op_vector[37:19];
            default: cur_comp = op_vector[18:0];
        endcase
    end

    // Magnitude multiply, truncate to Q8.10, saturate, and fix up the sign
    always_comb begin
        product  = {18'b0, cur_comp[17:0]} * {18'b0, op_scalar[17:0]};
        quot     = 26'(product >> 10);
        sat      = |quot[25:18];
        res_mag  = sat ? '1 : quot[17:0];
        // a zero magnitude always goes out as +0
        res_sign = (res_mag != '0) && (cur_comp[18] ^ op_scalar[18]);
    end

    // Operand capture and per-component result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vector  <= '0;
            op_scalar  <= '0;
            out_vector <= '0;
            out_ovf    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_vector <= in_vector;
                        op_scalar <= in_scalar;
                    end
                end
                MUL_X: begin
                    out_vector[56:38] <= {res_sign, res_mag};
                    out_ovf[2]        <= sat;
                end
                MUL_Y: begin
                    out_vector[37:19] <= {res_sign, res_mag};
                    out_ovf[1]        <= sat;
                end
                MUL_Z: begin
                    out_vector[18:0]  <= {res_sign, res_mag};
                    out_ovf[0]        <= sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_vector_scale.sv
// tb_signed_vector_scale: directed self-checking bench for signed_vector_scale.
module tb_signed_vector_scale;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] in_vector;
    logic [18:0] in_scalar;
    logic        out_valid;
    logic        out_ready;
    logic [56:0] out_vector;
    logic [2:0]  out_ovf;
    logic        busy;

    int checks;
    int failures;

    signed_vector_scale dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vector  (in_vector),
        .in_scalar  (in_scalar),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for in_ready, present operands for exactly one accept edge
    task automatic send(input logic [56:0] vec, input logic [18:0] sc);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout in_ready=%b required=1", in_ready);
        end
        in_vector = vec;
        in_scalar = sc;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Count edges after accept until out_valid is seen (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ready/valid/busy=%b%b%b required=100", in_ready, out_valid, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_vector !== 57'h0 || out_ovf !== 3'b000) begin
            failures++;
            $display("FAIL reset_data vec=%h ovf=%b required=0/000", out_vector, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int n;
        out_ready = 1'b1;
        send({19'h00400, 19'h40800, 19'h00200}, 19'h40600);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy busy/ready=%b%b required=10", busy, in_ready);
        end
        wait_valid(n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=3", n);
        end
        checks++;
        if (out_vector !== {19'h40600, 19'h00C00, 19'h40300}) begin
            failures++;
            $display("FAIL basic_vec got=%h required=%h", out_vector, {19'h40600, 19'h00C00, 19'h40300});
        end
        checks++;
        if (out_ovf !== 3'b000) begin
            failures++;
            $display("FAIL basic_ovf got=%b required=000", out_ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_handoff ready/valid=%b%b required=10", in_ready, out_valid);
        end
    endtask

    task automatic test_saturation;
        int n;
        out_ready = 1'b1;
        send({19'h32000, 19'h72000, 19'h00400}, 19'h00800);
        wait_valid(n);
        checks++;
        if (out_vector !== {19'h3FFFF, 19'h7FFFF, 19'h00800}) begin
            failures++;
            $display("FAIL sat_vec got=%h required=%h", out_vector, {19'h3FFFF, 19'h7FFFF, 19'h00800});
        end
        checks++;
        if (out_ovf !== 3'b110) begin
            failures++;
            $display("FAIL sat_ovf got=%b required=110", out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_trunc_zero;
        int n;
        out_ready = 1'b1;
        send({19'h00001, 19'h40000, 19'h00000}, 19'h40200);
        wait_valid(n);
        checks++;
        if (out_vector !== 57'h0) begin
            failures++;
            $display("FAIL trunc_zero_vec got=%h required=0", out_vector);
        end
        checks++;
        if (out_ovf !== 3'b000) begin
            failures++;
            $display("FAIL trunc_zero_ovf got=%b required=000", out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int n;
        int bad;
        out_ready = 1'b0;
        send({19'h00400, 19'h40800, 19'h00200}, 19'h40600);
        wait_valid(n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL bp_latency got=%0d required=3", n);
        end
        in_vector = {19'h00C00, 19'h00100, 19'h41000};
        in_scalar = 19'h00C00;
        in_valid  = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_vector !== {19'h40600, 19'h00C00, 19'h40300} || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d required=0 last_vec=%h ready=%b", bad, out_vector, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release ready/valid=%b%b required=10", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept busy/ready=%b%b required=10", busy, in_ready);
        end
        wait_valid(n);
        checks++;
        if (out_vector !== {19'h02400, 19'h00300, 19'h43000} || out_ovf !== 3'b000) begin
            failures++;
            $display("FAIL bp_next_vec got=%h/%b required=%h/000", out_vector, out_ovf, {19'h02400, 19'h00300, 19'h43000});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop;
        int seen;
        out_ready = 1'b1;
        send({19'h00400, 19'h40800, 19'h00200}, 19'h40600);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || out_vector[56:38] !== 19'h40600) begin
            failures++;
            $display("FAIL midop_pre busy=%b x=%h required=1/40600", busy, out_vector[56:38]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_vector !== 57'h0 || out_ovf !== 3'b000) begin
            failures++;
            $display("FAIL midop_async ready/valid/busy=%b%b%b vec=%h ovf=%b required=100/0/000",
                     in_ready, out_valid, busy, out_vector, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midop_no_valid active_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [56:0] vecs [5];
        logic [18:0] scs  [5];
        logic [56:0] exp_v[5];
        logic [2:0]  exp_o[5];
        logic [56:0] got_v;
        logic [2:0]  got_o;
        int k;
        vecs[0] = {19'h00400, 19'h00400, 19'h00400}; scs[0] = 19'h00400;
        exp_v[0] = {19'h00400, 19'h00400, 19'h00400}; exp_o[0] = 3'b000;
        vecs[1] = {19'h40C00, 19'h00A00, 19'h7FFFF}; scs[1] = 19'h40400;
        exp_v[1] = {19'h00C00, 19'h40A00, 19'h3FFFF}; exp_o[1] = 3'b000;
        vecs[2] = {19'h01000, 19'h00003, 19'h00000}; scs[2] = 19'h00002;
        exp_v[2] = {19'h00008, 19'h00000, 19'h00000}; exp_o[2] = 3'b000;
        vecs[3] = {19'h3FFFF, 19'h00001, 19'h40400}; scs[3] = 19'h3FFFF;
        exp_v[3] = {19'h3FFFF, 19'h000FF, 19'h7FFFF}; exp_o[3] = 3'b100;
        vecs[4] = {19'h00280, 19'h40280, 19'h00001}; scs[4] = 19'h40280;
        exp_v[4] = {19'h40190, 19'h00190, 19'h00000}; exp_o[4] = 3'b000;

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_vector = vecs[i];
            in_scalar = scs[i];
            @(posedge clk);
            #1;
            k = 0;
            got_v = '0;
            got_o = '0;
            while (!in_ready && k < 12) begin
                if (out_valid) begin
                    got_v = out_vector;
                    got_o = out_ovf;
                end
                @(posedge clk);
                #1;
                k++;
            end
            checks++;
            if (k != 4) begin
                failures++;
                $display("FAIL b2b_spacing[%0d] got=%0d required=4", i, k);
            end
            checks++;
            if (got_v !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_vec[%0d] got=%h required=%h", i, got_v, exp_v[i]);
            end
            checks++;
            if (got_o !== exp_o[i]) begin
                failures++;
                $display("FAIL b2b_ovf[%0d] got=%b required=%b", i, got_o, exp_o[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vector = '0;
        in_scalar = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_trunc_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_vector_scale.md
# signed_vector_scale

Sequential scaler that multiplies a 57-bit packed vector {x, y, z} by a 19-bit signed scalar, e.g. forming t·D for the ray point P = O + t·D. It sits directly upstream of the signed vector adder and produces a result in the same sign-magnitude fixed-point format that the adder consumes. A single shared 18×18 magnitude multiplier handles one component per cycle under a valid/ready handshake on both sides.

## Interface
- No parameters. Widths are fixed by the system number format.
- Number format: each 19-bit value is {sign[18], magnitude[17:0]}.
  - Magnitude is unsigned Q8.10: 8 integer bits, 10 fraction bits.
  - Sign 1 means negative.
  - Vector packing: x = [56:38], y = [37:19], z = [18:0].
- Clocking: one clock; reset is asynchronous and active-low.
- Ports:
  - clk, input, 1: sole clock; all state updates on the rising edge.
  - rst_n, input, 1: asynchronous active-low reset.
  - in_valid, input, 1: in_vector and in_scalar are valid.
  - in_ready, output, 1: block can accept an operand pair.
  - in_vector, input, 57: packed vector operand.
  - in_scalar, input, 19: sign-magnitude scalar operand.
  - out_valid, output, 1: out_vector and out_ovf are valid.
  - out_ready, input, 1: downstream accepts the result.
  - out_vector, output, 57: packed scaled vector, same format as the input.
  - out_ovf, output, 3: per-component saturation flags {x, y, z}.
  - busy, output, 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, MUL_X, MUL_Y, MUL_Z and DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, the operands are registered and the state moves to MUL_X.
  - Upstream may change its inputs freely after the accept edge.
- MUL_X, MUL_Y, MUL_Z:
  - One component per state, in that order.
  - The result is written into its out_vector field and out_ovf bit, then the state advances.
  - in_ready = 0.
- DONE:
  - out_valid = 1.
  - out_vector and out_ovf are held stable until out_ready is high.
  - When out_valid and out_ready are both high, the state returns to IDLE.
- Per-component arithmetic:
  - p = mag_v × mag_s, a 36-bit product in Q16.20.
  - q = p[35:10], i.e. truncate toward zero by dropping 10 fraction bits.
  - If q[25:18] ≠ 0: magnitude = 18'h3FFFF and the ovf bit = 1.
  - Otherwise: magnitude = q[17:0] and the ovf bit = 0.
  - sign = sign_v XOR sign_s.
  - If the resulting magnitude is 0, sign is forced to 0, so no negative zero is ever emitted.
- Reset, including mid-operation: the state goes to IDLE and every output and operand register clears asynchronously. Partial results are discarded.
- Input is never accepted outside IDLE; there is no overlap of operations.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, busy = 0.
  - out_vector = 57'h0, out_ovf = 3'b000.
- Latency: if the accept edge is cycle 0, out_valid rises after the edge of cycle 3, i.e. it is visible in cycle 3.
- Result hand-off:
  - If out_ready is already high in cycle 3, the transfer happens on that edge and in_ready is high in cycle 4.
  - Best-case throughput is one vector per 4 cycles.
- Backpressure: out_ready held low keeps the block in DONE indefinitely. Outputs stay stable and in_ready stays 0.
- in_valid is ignored when in_ready = 0.
- out_vector fields update one per cycle during MUL_*. Their contents are defined only while out_valid = 1.

## Test plan
- Basic scaling:
  - Stimulus: in_vector = {0x00400, 0x40800, 0x00200} (1.0, -2.0, 0.5); in_scalar = 0x40600 (-1.5); out_ready = 1.
  - Required: out_vector = {0x40600, 0x00C00, 0x40300}, out_ovf = 0, and out_valid high exactly 3 cycles after accept.
- Saturation:
  - Stimulus: x = 0x32000 (200.0), y = 0x72000 (-200.0), z = 0x00400; scalar = 0x00800 (2.0).
  - Required: x = 0x3FFFF, y = 0x7FFFF, z = 0x00800, out_ovf = 3'b110.
- Truncation and zero sign:
  - Stimulus: x = 0x00001 (1/1024), y = 0x40000 (-0), z = 0x00000; scalar = 0x40200 (-0.5).
  - Required: all components 0x00000 with sign 0, out_ovf = 0.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid rises, and drive in_valid high with new operands throughout.
  - Required: out_vector is unchanged and in_ready stays 0. After out_ready pulses, the new operands are accepted in the following cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 asynchronously while in MUL_Y.
  - Required: outputs return to their reset values immediately, without waiting for a clock edge. After release, no out_valid appears until a new accept.
- Back-to-back:
  - Stimulus: 5 random operand pairs with in_valid and out_ready held high.
  - Required: each result matches the reference model, and the accepts are spaced exactly 4 cycles apart.
